// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - async FIFO read-side pointer/empty controller; optional level logic under RD_LEVEL_EN
module fifo_read_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  R_CLK,
    input  logic                  R_rst_n,
    input  logic                  R_en,
    input  logic [ADDR_WIDTH:0]   Rq2_wptr,
    output logic                  R_ren,
    output logic [ADDR_WIDTH-1:0] R_addr,
    output logic [ADDR_WIDTH:0]   R_ptr,
    output logic                  R_empty,
    output logic                  R_underflow
`ifdef RD_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   R_level,
    output logic                  R_almost_empty
`endif
);

    logic [ADDR_WIDTH:0] r_bin;
    logic [ADDR_WIDTH:0] w_bin_next;
    logic [ADDR_WIDTH:0] w_gray_next;

    // The registered empty flag gates the strobe, so a pop can never be issued into an empty RAM.
    assign R_ren       = R_en & ~R_empty;
    assign R_addr      = r_bin[ADDR_WIDTH-1:0];
    assign w_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, R_ren};
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            r_bin       <= '0;
            R_ptr       <= '0;
            R_empty     <= 1'b1;
            R_underflow <= 1'b0;
        end else begin
            r_bin       <= w_bin_next;
            R_ptr       <= w_gray_next;
            // Comparing the next pointer lets the last-word pop set empty on its own edge.
            R_empty     <= (w_gray_next == Rq2_wptr);
            R_underflow <= R_en & R_empty;
        end
    end

`ifdef RD_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AE_TH = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] w_wbin;
    logic [ADDR_WIDTH:0] w_level_next;

    always_comb begin
        w_wbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            w_wbin[i] = ^(Rq2_wptr >> i);
        end
    end

    assign w_level_next = w_wbin - w_bin_next;

    always_ff @(posedge R_CLK or negedge R_rst_n) begin
        if (!R_rst_n) begin
            R_level        <= '0;
            R_almost_empty <= 1'b1;
        end else begin
            R_level        <= w_level_next;
            R_almost_empty <= (w_level_next <= AE_TH);
        end
    end
`endif

endmodule
